// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             commit;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_valid;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             is_sdiv;
    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_abs;
    logic [31:0]      b_abs;
    logic [31:0]      num;
    logic [31:0]      den;
    logic [31:0]      den_safe;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign prod_s = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
    assign prod_u = {32'b0, A_E} * {32'b0, B_E};

    // Signed divide done on magnitudes so truncation toward zero and the
    // dividend-signed remainder fall out of the sign fix-up below.
    always_comb begin
        is_sdiv  = (MDOp == OP_DIV);
        a_neg    = A_E[31];
        b_neg    = B_E[31];
        a_abs    = a_neg ? (32'd0 - A_E) : A_E;
        b_abs    = b_neg ? (32'd0 - B_E) : B_E;
        num      = is_sdiv ? a_abs : A_E;
        den      = is_sdiv ? b_abs : B_E;
        // Divide by zero must not produce X; its result is discarded anyway.
        den_safe = (den == 32'd0) ? 32'd1 : den;
        q_mag    = num / den_safe;
        r_mag    = num % den_safe;
        quot     = (is_sdiv && (a_neg ^ b_neg)) ? (32'd0 - q_mag) : q_mag;
        rem      = (is_sdiv && a_neg) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                accept = Start;
                if (Start) begin
                    if (MDOp == OP_MULT || MDOp == OP_MULTU) begin
                        state_next = S_RUN;
                        cnt_next   = MULT_LOAD;
                    end else if (MDOp == OP_DIV || MDOp == OP_DIVU) begin
                        state_next = S_RUN;
                        cnt_next   = DIV_LOAD;
                    end
                end
            end
            S_RUN: begin
                if (cnt <= CNT_ONE) begin
                    commit     = 1'b1;
                    state_next = S_IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Result is held privately until the final edge so HI/LO never expose it early.
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI        <= 32'd0;
            LO        <= 32'd0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            res_valid <= 1'b0;
        end else begin
            if (accept) begin
                case (MDOp)
                    OP_MULT: begin
                        res_hi    <= prod_s[63:32];
                        res_lo    <= prod_s[31:0];
                        res_valid <= 1'b1;
                    end
                    OP_MULTU: begin
                        res_hi    <= prod_u[63:32];
                        res_lo    <= prod_u[31:0];
                        res_valid <= 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        res_hi    <= rem;
                        res_lo    <= quot;
                        res_valid <= (B_E != 32'd0);
                    end
                    OP_MTHI: HI <= A_E;
                    OP_MTLO: LO <= A_E;
                    default: ;
                endcase
            end
            if (commit && res_valid) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end

    assign Busy = (state == S_RUN);

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    int total;
    int bad;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A_E   (A_E),
        .B_E   (B_E),
        .HI    (HI),
        .LO    (LO),
        .Busy  (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic busy_exp,
                             input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        chk({tag, ".busy"}, {31'd0, Busy}, {31'd0, busy_exp});
        chk({tag, ".hi"}, HI, hi_exp);
        chk({tag, ".lo"}, LO, lo_exp);
    endtask

    // Issue one op, scramble operands during RUN, and check Busy/HI/LO every cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] new_hi, input logic [31:0] new_lo);
        Start = 1'b1;
        MDOp  = op;
        A_E   = a;
        B_E   = b;
        tick();
        Start = 1'b0;
        A_E   = ~a;
        B_E   = ~b;
        for (int i = 0; i < n; i++) begin
            chk_state({tag, ".run"}, 1'b1, old_hi, old_lo);
            tick();
        end
        chk_state({tag, ".done"}, 1'b0, new_hi, new_lo);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        Start = 1'b1;
        MDOp  = 3'd1;
        A_E   = 32'd3;
        B_E   = 32'd5;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("reset_hold", 1'b0, 32'd0, 32'd0);
        end
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        tick();
        chk_state("reset_release", 1'b0, 32'd0, 32'd0);

        run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 5,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFE);

        Start = 1'b1;
        MDOp  = 3'd6;
        A_E   = 32'h12345678;
        tick();
        Start = 1'b0;
        chk_state("mtlo", 1'b0, 32'h00000001, 32'h12345678);

        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000001, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFD);

        Start = 1'b1;
        MDOp  = 3'd5;
        A_E   = 32'hAAAA0000;
        tick();
        Start = 1'b0;
        chk_state("mthi", 1'b0, 32'hAAAA0000, 32'hFFFFFFFD);

        run_op("divu_by_zero", 3'd4, 32'd5, 32'd0, 10,
               32'hAAAA0000, 32'hFFFFFFFD, 32'hAAAA0000, 32'hFFFFFFFD);

        run_op("div_overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               32'hAAAA0000, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);

        run_op("divu", 3'd4, 32'hFFFFFFFF, 32'd16, 10,
               32'h00000000, 32'h80000000, 32'h0000000F, 32'h0FFFFFFF);

        run_op("reserved", 3'd7, 32'h11111111, 32'd2, 0,
               32'h0000000F, 32'h0FFFFFFF, 32'h0000000F, 32'h0FFFFFFF);

        // mult 7*6 at t0; div at t0+2 and mthi at t0+3 must be ignored.
        Start = 1'b1;
        MDOp  = 3'd1;
        A_E   = 32'd7;
        B_E   = 32'd6;
        tick();
        Start = 1'b0;
        chk_state("busy_ign.t0", 1'b1, 32'h0000000F, 32'h0FFFFFFF);
        tick();
        Start = 1'b1;
        MDOp  = 3'd3;
        A_E   = 32'd100;
        B_E   = 32'd3;
        tick();
        MDOp  = 3'd5;
        A_E   = 32'h55555555;
        tick();
        Start = 1'b0;
        chk_state("busy_ign.t3", 1'b1, 32'h0000000F, 32'h0FFFFFFF);
        tick();
        Start = 1'b1;
        MDOp  = 3'd6;
        A_E   = 32'hDEADBEEF;
        tick();
        Start = 1'b0;
        chk_state("busy_ign.t5", 1'b0, 32'h00000000, 32'd42);

        run_op("div_after", 3'd3, 32'd100, 32'd3, 10,
               32'h00000000, 32'd42, 32'd1, 32'd33);

        // Reset asserted at t0+3 of a div: everything clears and no late write follows.
        Start = 1'b1;
        MDOp  = 3'd3;
        A_E   = 32'd100;
        B_E   = 32'd7;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk_state("rst_mid.t2", 1'b1, 32'd1, 32'd33);
        reset = 1'b0;
        tick();
        chk_state("rst_mid.t3", 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_state("rst_mid.after", 1'b0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
